// File: rtl/cgr_pkg.sv
// cgr_pkg: shared CGR parameters, address helpers and histogram FSM states.
// Imported by the address generator and every downstream CGR consumer.
package cgr_pkg;

    localparam int CGR_DATA_LEN = 3;

    typedef enum logic [1:0] {IDLE, CLEAR, DUMP} hist_state_t;

    function automatic int cgr_aw(input int dl);
        return 2 * dl + 2;
    endfunction

    function automatic int cgr_depth(input int dl);
        return 1 << (2 * dl);
    endfunction

    // Packed address is {1'b0, x, 1'b0, y}; the pad bits are dropped.
    function automatic logic [15:0] cgr_idx(input logic [33:0] addr, input int dl);
        logic [33:0] m;
        m = (34'd1 << dl) - 34'd1;
        return 16'((((addr >> (dl + 1)) & m) << dl) | (addr & m));
    endfunction

endpackage

// File: rtl/cgr_hist_if.sv
// cgr_hist_if: increment strobe, control pulses and dump stream of the k-mer histogram.
interface cgr_hist_if
    import cgr_pkg::*;
#(
    parameter int DATA_LEN = CGR_DATA_LEN,
    parameter int CNT_W    = 16
);
    logic [cgr_aw(DATA_LEN)-1:0] addr;
    logic                        wen_cgr;
    logic                        clr;
    logic                        dump;
    logic                        busy;
    logic                        dout_valid;
    logic                        dout_ready;
    logic [2*DATA_LEN-1:0]       dout_idx;
    logic [CNT_W-1:0]            dout_cnt;
    logic                        sat;
    logic                        drop;

    modport master (
        output addr, wen_cgr, clr, dump, dout_ready,
        input  busy, dout_valid, dout_idx, dout_cnt, sat, drop
    );

    modport slave (
        input  addr, wen_cgr, clr, dump, dout_ready,
        output busy, dout_valid, dout_idx, dout_cnt, sat, drop
    );
endinterface

// File: rtl/cgr_hist_out.sv
// cgr_hist_out: dump output register; walks the read pointer and holds beats under backpressure.
module cgr_hist_out #(
    parameter int IW    = 6,
    parameter int CNT_W = 16
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             active_i,
    input  logic             ready_i,
    input  logic [CNT_W-1:0] rd_data_i,
    output logic [IW-1:0]    rd_ptr_o,
    output logic             valid_o,
    output logic [IW-1:0]    idx_o,
    output logic [CNT_W-1:0] cnt_o,
    output logic             done_o
);
    logic [IW-1:0]    ptr_q, ptr_d, idx_q, idx_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             valid_q, valid_d, loaded_q, loaded_d;
    logic             fire, load;

    // loaded_q marks that the last cell is already in the output register.
    always_comb begin
        fire     = valid_q && ready_i;
        load     = active_i && !loaded_q && (!valid_q || fire);
        ptr_d    = !active_i ? '0 : load ? ptr_q + IW'(1) : ptr_q;
        loaded_d = active_i && (loaded_q || (load && &ptr_q));
        valid_d  = active_i && (load || (valid_q && !ready_i));
        idx_d    = load ? ptr_q : idx_q;
        cnt_d    = load ? rd_data_i : cnt_q;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            ptr_q    <= '0;
            idx_q    <= '0;
            cnt_q    <= '0;
            valid_q  <= 1'b0;
            loaded_q <= 1'b0;
        end else begin
            ptr_q    <= ptr_d;
            idx_q    <= idx_d;
            cnt_q    <= cnt_d;
            valid_q  <= valid_d;
            loaded_q <= loaded_d;
        end
    end

    assign rd_ptr_o = ptr_q;
    assign valid_o  = valid_q;
    assign idx_o    = idx_q;
    assign cnt_o    = cnt_q;
    assign done_o   = fire && loaded_q;
endmodule

// File: rtl/cgr_hist.sv
// cgr_hist: saturating per-cell CGR k-mer histogram with clear and streaming dump.
// Define CGR_HIST_TOTAL_EN to add the 32-bit 'total' accepted-increment counter port.
module cgr_hist
    import cgr_pkg::*;
#(
    parameter int DATA_LEN = CGR_DATA_LEN,
    parameter int CNT_W    = 16
) (
    input  logic        CLK,
    input  logic        RST_N,
    cgr_hist_if.slave   bus
`ifdef CGR_HIST_TOTAL_EN
    ,
    output logic [31:0] total
`endif
);
    localparam int IW    = 2 * DATA_LEN;
    localparam int DEPTH = cgr_depth(DATA_LEN);

    hist_state_t      state_q, state_d;
    logic [CNT_W-1:0] mem_q [DEPTH];
    logic [IW-1:0]    s1_idx_q, s1_idx_d, clr_ptr_q, clr_ptr_d, rd_ptr;
    logic             s1_v_q, s1_v_d, sat_q, sat_d, drop_q, drop_d;
    logic             idle, go_clr, go_dump, commit, full, dump_done;

    // Strobes coinciding with clr/dump are not captured; a pending one commits on the dump edge.
    always_comb begin
        idle      = state_q == IDLE;
        go_clr    = idle && bus.clr;
        go_dump   = idle && bus.dump && !bus.clr;
        commit    = idle && s1_v_q && !bus.clr;
        full      = &mem_q[s1_idx_q];
        s1_v_d    = idle && bus.wen_cgr && !bus.clr && !bus.dump;
        s1_idx_d  = s1_v_d ? IW'(cgr_idx(34'(bus.addr), DATA_LEN)) : s1_idx_q;
        clr_ptr_d = state_q == CLEAR ? clr_ptr_q + IW'(1) : '0;
        state_d   = go_clr ? CLEAR
                  : go_dump ? DUMP
                  : ((state_q == CLEAR && &clr_ptr_q) || dump_done) ? IDLE
                  : state_q;
        sat_d     = go_clr ? 1'b0 : sat_q | (commit && full);
        drop_d    = go_clr ? 1'b0 : drop_q | (!idle && bus.wen_cgr);
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q   <= IDLE;
            s1_v_q    <= 1'b0;
            s1_idx_q  <= '0;
            clr_ptr_q <= '0;
            sat_q     <= 1'b0;
            drop_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            s1_v_q    <= s1_v_d;
            s1_idx_q  <= s1_idx_d;
            clr_ptr_q <= clr_ptr_d;
            sat_q     <= sat_d;
            drop_q    <= drop_d;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (state_q == CLEAR) begin
            mem_q[clr_ptr_q] <= '0;
        end else if (commit && !full) begin
            mem_q[s1_idx_q] <= mem_q[s1_idx_q] + CNT_W'(1);
        end
    end

`ifdef CGR_HIST_TOTAL_EN
    logic [31:0] total_q;
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) total_q <= '0;
        else total_q <= go_clr ? '0 : commit ? total_q + 32'd1 : total_q;
    end
    assign total = total_q;
`endif

    cgr_hist_out #(.IW(IW), .CNT_W(CNT_W)) u_out (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .active_i  (state_q == DUMP),
        .ready_i   (bus.dout_ready),
        .rd_data_i (mem_q[rd_ptr]),
        .rd_ptr_o  (rd_ptr),
        .valid_o   (bus.dout_valid),
        .idx_o     (bus.dout_idx),
        .cnt_o     (bus.dout_cnt),
        .done_o    (dump_done)
    );

    assign bus.busy = !idle;
    assign bus.sat  = sat_q;
    assign bus.drop = drop_q;
endmodule
